// File: rtl/ram_port_arbiter_if.sv
// Requester and RAM-side signals of the two-port RAM arbiter.
// master: the requesters plus the RAM read data; slave: the arbiter.
interface ram_port_arbiter_if #(
  parameter int AW = 7,
  parameter int DW = 32
);
  logic          req0, we0, lock0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          gnt0, rvalid0;
  logic [DW-1:0] rdata0;

  logic          req1, we1, lock1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          gnt1, rvalid1;
  logic [DW-1:0] rdata1;

  logic          ram_wea;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [DW-1:0] ram_dina, ram_doutb;

  modport master (
    output req0, we0, lock0, addr0, wdata0,
    output req1, we1, lock1, addr1, wdata1,
    output ram_doutb,
    input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
    input  ram_wea, ram_addra, ram_addrb, ram_dina
  );

  modport slave (
    input  req0, we0, lock0, addr0, wdata0,
    input  req1, we1, lock1, addr1, wdata1,
    input  ram_doutb,
    output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
    output ram_wea, ram_addra, ram_addrb, ram_dina
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter in front of a 1W/1R-comb data RAM.
// One beat per cycle, optional bounded lock for read-modify-write, and a
// registered one-cycle read response per requester.
module ram_port_arbiter #(
  parameter int AW       = 7,
  parameter int DW       = 32,
  parameter int LOCK_MAX = 4
) (
  input logic              clk,
  input logic              rst,
  ram_port_arbiter_if.slave bus
);
  typedef enum logic {ARB, LOCKED} state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic          owner_q, owner_d;
  logic [3:0]    lcnt_q, lcnt_d;
  logic [1:0]    rvalid_q, rvalid_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic          gnt0, gnt1, acc, sel, sel_we, sel_lock;
  logic          own_req, own_lock;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // Grant selection: the lock owner is exclusive, otherwise the requester
  // that was not served last wins a conflict. Nothing is granted in reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (state_q == LOCKED) begin
        gnt0 = !owner_q && bus.req0;
        gnt1 = owner_q && bus.req1;
      end else if (bus.req0 && bus.req1) begin
        gnt0 = last_q;
        gnt1 = !last_q;
      end else begin
        gnt0 = bus.req0;
        gnt1 = bus.req1;
      end
    end
    acc       = gnt0 | gnt1;
    sel       = gnt1;
    sel_we    = sel ? bus.we1    : bus.we0;
    sel_lock  = sel ? bus.lock1  : bus.lock0;
    sel_addr  = sel ? bus.addr1  : bus.addr0;
    sel_wdata = sel ? bus.wdata1 : bus.wdata0;
    own_req   = owner_q ? bus.req1  : bus.req0;
    own_lock  = owner_q ? bus.lock1 : bus.lock0;
  end

  // RAM drive follows the granted requester; idle bus is all zeros so the
  // RAM never sees stale addresses.
  always_comb begin
    bus.gnt0      = gnt0;
    bus.gnt1      = gnt1;
    bus.ram_wea   = acc && sel_we;
    bus.ram_addra = acc ? sel_addr  : '0;
    bus.ram_addrb = acc ? sel_addr  : '0;
    bus.ram_dina  = acc ? sel_wdata : '0;
    bus.rvalid0   = rvalid_q[0];
    bus.rvalid1   = rvalid_q[1];
    bus.rdata0    = rdata0_q;
    bus.rdata1    = rdata1_q;
  end

  // Next-state: round-robin pointer, lock FSM with beat counter, and the
  // read response capture (rvalid is a single-cycle pulse).
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner_q;
    lcnt_d   = lcnt_q;
    rvalid_d = 2'b00;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;

    if (acc) last_d = sel;

    if (acc && !sel_we) begin
      if (sel) begin
        rvalid_d[1] = 1'b1;
        rdata1_d    = bus.ram_doutb;
      end else begin
        rvalid_d[0] = 1'b1;
        rdata0_d    = bus.ram_doutb;
      end
    end

    case (state_q)
      ARB: begin
        if (acc && sel_lock && (LOCK_MAX > 1)) begin
          state_d = LOCKED;
          owner_d = sel;
          lcnt_d  = 4'd0;
        end
      end
      LOCKED: begin
        if (!own_req || !own_lock) begin
          // Owner released voluntarily; its last granted beat (if any)
          // already moved last to the owner.
          state_d = ARB;
          lcnt_d  = 4'd0;
        end else if (lcnt_q + 4'd1 == 4'(LOCK_MAX - 1)) begin
          // Forced timeout: mark the owner as last so the waiting side
          // wins the next conflict.
          state_d = ARB;
          lcnt_d  = 4'd0;
          last_d  = owner_q;
        end else begin
          lcnt_d = lcnt_q + 4'd1;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // State registers; reset leaves requester 0 as the first conflict winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ARB;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      lcnt_q   <= 4'd0;
      rvalid_q <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      lcnt_q   <= lcnt_d;
      rvalid_q <= rvalid_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Two-requester arbiter in front of the 128x32 data RAM (one write port, one combinational read port).
- Shares the RAM between requester 0 (core datapath) and requester 1 (debug/DMA side).
- Serves at most one transaction per cycle. The RAM read port returns write data whenever wea=1, so a read cannot be overlapped with a write.
- Round-robin arbitration, optional bounded lock for atomic read-modify-write, registered read response.

Parameters:
- AW, 7, RAM address width.
- DW, 32, RAM data width.
- LOCK_MAX, 4, maximum consecutive cycles a locked requester keeps ownership (1..15).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous active-high reset.
- req0  input  1  requester 0 transaction request.
- we0  input  1  requester 0 write (1) / read (0).
- lock0  input  1  requester 0 holds ownership across consecutive beats.
- addr0  input  AW  requester 0 address.
- wdata0  input  DW  requester 0 write data.
- gnt0  output  1  requester 0 accepted this cycle (combinational).
- rvalid0  output  1  requester 0 read data valid (registered).
- rdata0  output  DW  requester 0 read data.
- req1, we1, lock1, addr1, wdata1, gnt1, rvalid1, rdata1: same as requester 0, for requester 1.
- ram_wea  output  1  to RAM wea.
- ram_addra  output  AW  to RAM addra.
- ram_dina  output  DW  to RAM dina.
- ram_addrb  output  AW  to RAM addrb.
- ram_doutb  input  DW  from RAM doutb.

Behaviour:
- State: owner pointer `last` (1 bit, last granted requester), FSM {ARB, LOCKED}, lock counter `lcnt` (4 bits), rvalid0/1, rdata0/1.
- Reset (async): FSM=ARB, last=1 (so requester 0 wins the first conflict), lcnt=0, rvalid0=rvalid1=0, rdata0=rdata1=0.
- While rst is high: gnt0=gnt1=0 and ram_wea=0.
- Transaction accepted when reqN && gntN in the same cycle. gnt0 and gnt1 are never both 1.
- ARB:
  - Only one requester asserting req: that requester is granted.
  - Both requesting: grant goes to the requester != last.
  - No request: no grant, last unchanged.
- LOCKED (owner O):
  - Only O can be granted. The other requester's gnt=0 even if it requests.
  - Exit to ARB when O drops lock, O drops req, or lcnt reaches LOCK_MAX-1 on a granted beat.
- ARB->LOCKED: on a granted beat with lockN=1 and LOCK_MAX>1. lcnt=0, owner=N.
- LOCKED with granted beat: lcnt+1.
- Leaving LOCKED on a forced timeout sets last=O, so the waiting requester wins the next conflict.
- last updates to the granted index on every accepted beat.
- RAM drive (combinational from the granted requester):
  - ram_addra=ram_addrb=addrN.
  - ram_dina=wdataN.
  - ram_wea=reqN&&gntN&&weN.
- No grant: ram_wea=0, addresses/data=0.
- Write: RAM updated at the same rising edge; no response pulse.
- Read: at the accepting edge, rdataN<=ram_doutb and rvalidN<=1. rvalidN is high for exactly one cycle; latency is 1 cycle.
- Back-to-back reads give back-to-back rvalid. rdataN holds its last value when rvalidN=0.
- Read-after-write to the same address on consecutive cycles returns the new data.
- A read and a write in the same cycle is impossible by construction.
- Reset mid-lock: returns to ARB immediately. Pending rvalid is cleared.

Test Plan:
- Reset then req0 write addr=0x05 data=0xDEADBEEF; next cycle req0 read addr=0x05 -> gnt0 both cycles, ram_wea=1 only on the first, rvalid0=1 one cycle later with rdata0=0xDEADBEEF.
- req0 and req1 reads held continuously for 6 cycles, addr0=0x01, addr1=0x02 -> grants alternate 0,1,0,1,0,1; each rvalid pulses on alternate cycles with correct data.
- req1 lock1=1 read/write burst of 6 beats while req0 held, LOCK_MAX=4 -> gnt1 for 4 consecutive cycles, then gnt0, then gnt1 resumes.
- Requester 1 locked; lock1 dropped after 2 beats while req0 pending -> ownership released, gnt0 on the next cycle.
- Assert rst in the middle of a locked burst with a read just accepted -> gnt0=gnt1=0, rvalid cleared, FSM=ARB; after release, a conflict is won by requester 0.
- Single requester req1 alone for 5 cycles, addrs 0x7F wrapping to 0x00 -> gnt1 every cycle, no stall, correct data at 0x7F and 0x00.
